pong_ball_str: RTL

Pixel-stream stage that consumes the 23-bit VGA stream produced by the stream VGA generator and adds the pong ball on top of it. It keeps the ball position, direction and scores, and advances the ball once per frame. Every pixel of the input stream is re-emitted with a 2-cycle delay, together with a 3-bit RGB value aligned to it. It sits between the stream generator and the colour/DAC output stage.

---
 rtl/pong_ball_str.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pong_ball_str.sv
// pong_ball_str
// Pixel-stream stage that overlays the pong ball on a 23-bit VGA stream.
// The stage keeps the ball position, direction and scores, and advances the
// ball once per frame. Every input pixel is re-emitted two cycles later with
// an aligned 3-bit RGB value.
//
// Ports
//   px_clk      pixel clock (only clock)
//   rst_n       synchronous active-low reset
//   strVGA_in   [9:0] x_px, [19:10] y_px, [20] hsync, [21] vsync, [22] activevideo
//   pause       freezes game state on frame ticks
//   strVGA_out  strVGA_in delayed by two cycles
//   rgb         colour for the pixel currently on strVGA_out
//   score_l     left player score, saturates at 9
//   score_r     right player score, saturates at 9
//   frame_tick  one-cycle pulse at the falling edge of vsync
//
// Optional feature macro: PONG_BALL_BORDER_EN
//   When defined, active pixels on the outer screen edge are drawn white and
//   take priority over the ball.
//
// FSM states
//   state    | meaning
//   ST_SERVE | ball hidden, counting frames until the next serve
//   ST_MOVE  | ball visible, moving and bouncing each frame
module pong_ball_str #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter logic [2:0]  BALL_COLOR   = 3'b111
) (
  input  logic        px_clk,
  input  logic        rst_n,
  input  logic [22:0] strVGA_in,
  input  logic        pause,
  output logic [22:0] strVGA_out,
  output logic [2:0]  rgb,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        frame_tick
);

  localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // 11-bit compare domain so that bx + BALL_SIZE never wraps.
  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] SPD11 = 11'(SPEED);
  localparam logic [10:0] BSZ11 = 11'(BALL_SIZE);
  localparam logic [9:0]  SPD10 = 10'(SPEED);
  localparam logic [9:0]  X_CTR = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_CTR = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [3:0]  SCORE_MAX = 4'd9;

  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_MOVE  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      bx_q, bx_d;
  logic [9:0]      by_q, by_d;
  logic            dx_left_q, dx_left_d;
  logic            dy_up_q, dy_up_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      score_l_q, score_l_d;
  logic [3:0]      score_r_q, score_r_d;

  logic            vs_q;
  logic            tick_q;
  logic            step;
  logic            ball_vis;

  logic [22:0]     s1_q, s2_q;
  logic            hit_q, hit_d;
  logic [2:0]      rgb_q, rgb_d;

  logic [10:0]     bx_ext, by_ext;
  logic [10:0]     x_in, y_in;
  logic            av_in;

  assign bx_ext = {1'b0, bx_q};
  assign by_ext = {1'b0, by_q};
  assign x_in   = {1'b0, strVGA_in[9:0]};
  assign y_in   = {1'b0, strVGA_in[19:10]};
  assign av_in  = strVGA_in[22];

  // Frame tick: vsync register resets high so reset never produces a tick.
  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      vs_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      vs_q   <= strVGA_in[21];
      tick_q <= vs_q & ~strVGA_in[21];
    end
  end

  assign step = tick_q & ~pause;

  // State register
  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      state_q   <= ST_SERVE;
      bx_q      <= X_CTR;
      by_q      <= Y_CTR;
      dx_left_q <= 1'b0;
      dy_up_q   <= 1'b0;
      cnt_q     <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
    end else begin
      state_q   <= state_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dx_left_q <= dx_left_d;
      dy_up_q   <= dy_up_d;
      cnt_q     <= cnt_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  // Next-state logic, evaluated only on unpaused frame ticks
  always_comb begin
    state_d   = state_q;
    bx_d      = bx_q;
    by_d      = by_q;
    dx_left_d = dx_left_q;
    dy_up_d   = dy_up_q;
    cnt_d     = cnt_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;

    if (step) begin
      case (state_q)
        ST_SERVE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            bx_d    = X_CTR;
            by_d    = Y_CTR;
            state_d = ST_MOVE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_MOVE: begin
          if (dy_up_q) begin
            if (by_ext < SPD11) begin
              by_d    = '0;
              dy_up_d = 1'b0;
            end else begin
              by_d = by_q - SPD10;
            end
          end else begin
            if (by_ext + SPD11 > Y_MAX) begin
              by_d    = Y_MAX[9:0];
              dy_up_d = 1'b1;
            end else begin
              by_d = by_q + SPD10;
            end
          end

          // A miss leaves dx unchanged, so the next serve heads toward the
          // player who conceded.
          if (dx_left_q) begin
            if (bx_ext < SPD11) begin
              if (score_r_q != SCORE_MAX) begin
                score_r_d = score_r_q + 4'd1;
              end
              state_d = ST_SERVE;
            end else begin
              bx_d = bx_q - SPD10;
            end
          end else begin
            if (bx_ext + SPD11 > X_MAX) begin
              if (score_l_q != SCORE_MAX) begin
                score_l_d = score_l_q + 4'd1;
              end
              state_d = ST_SERVE;
            end else begin
              bx_d = bx_q + SPD10;
            end
          end
        end

        default: state_d = ST_SERVE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    ball_vis = 1'b0;
    case (state_q)
      ST_MOVE:  ball_vis = 1'b1;
      default:  ball_vis = 1'b0;
    endcase
  end

  // Pixel path, stage 1: ball hit test against the live ball registers.
  // Those registers only change during vsync, never inside active video.
  assign hit_d = av_in & ball_vis &
                 (x_in >= bx_ext) & (x_in < bx_ext + BSZ11) &
                 (y_in >= by_ext) & (y_in < by_ext + BSZ11);

`ifdef PONG_BALL_BORDER_EN
  logic border_q, border_d;

  assign border_d = av_in &
                    ((x_in == 11'd0) | (x_in == 11'(H_ACTIVE - 1)) |
                     (y_in == 11'd0) | (y_in == 11'(V_ACTIVE - 1)));

  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      border_q <= 1'b0;
    end else begin
      border_q <= border_d;
    end
  end

  assign rgb_d = border_q ? 3'b111 : (hit_q ? BALL_COLOR : 3'b000);
`else
  assign rgb_d = hit_q ? BALL_COLOR : 3'b000;
`endif

  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      s1_q  <= '0;
      hit_q <= 1'b0;
      s2_q  <= '0;
      rgb_q <= '0;
    end else begin
      s1_q  <= strVGA_in;
      hit_q <= hit_d;
      s2_q  <= s1_q;
      rgb_q <= rgb_d;
    end
  end

  assign strVGA_out = s2_q;
  assign rgb        = rgb_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign frame_tick = tick_q;

endmodule
